minimac_wbmem: RTL and testbench

MINIMAC_WBMEM -- requirements
Module: minimac_wbmem

---
 rtl/minimac_wbmem.sv | 146 ++++++++++++++
 tb/tb_minimac_wbmem.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/minimac_wbmem.sv
// minimac_wbmem: shared packet-buffer RAM behind two Wishbone B3 slaves.
//   RX port (write-only) and TX port (read-only) share one single-port RAM of
//   2^AW x 32-bit words. A three-state arbiter grants one port at a time,
//   with round-robin tie-breaking.
// Parameters:
//   AW    word-address width (RAM depth 2^AW words)
//   BASE  byte base address of the buffer window
// Ports:
//   sys_clk, sys_rst_n          clock, asynchronous active-low reset
//   wbrx_*                      RX slave: adr/cti/cyc/stb/dat in, ack/err out
//   wbtx_*                      TX slave: adr/cti/cyc/stb in, dat/ack/err out
// Optional feature (macro MINIMAC_WBMEM_ERR_EN): beats whose address lies
//   outside the BASE window get err instead of ack and are not performed.
//   Without it, err outputs stay 0 and addresses wrap modulo 2^AW words.
module minimac_wbmem #(
  parameter int unsigned AW   = 9,
  parameter logic [31:0] BASE = 32'h0000_0000
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  // RX port (write)
  input  logic [31:0] wbrx_adr_i,
  input  logic [2:0]  wbrx_cti_i,
  input  logic        wbrx_cyc_i,
  input  logic        wbrx_stb_i,
  input  logic [31:0] wbrx_dat_i,
  output logic        wbrx_ack_o,
  output logic        wbrx_err_o,
  // TX port (read)
  input  logic [31:0] wbtx_adr_i,
  input  logic [2:0]  wbtx_cti_i,
  input  logic        wbtx_cyc_i,
  input  logic        wbtx_stb_i,
  output logic [31:0] wbtx_dat_o,
  output logic        wbtx_ack_o,
  output logic        wbtx_err_o
);

  typedef enum logic [1:0] {StIdle, StGntRx, StGntTx} state_e;

  state_e      state_q;
  logic        last_tx_q;  // 1: TX was the port served most recently
  logic        burst_q;    // last accepted beat was an incrementing-burst beat
  logic        rx_ack_q, rx_err_q, tx_ack_q, tx_err_q;
  logic [31:0] tx_dat_q;

  logic [31:0] mem [2**AW];

  logic          rx_req, tx_req;
  logic [AW-1:0] rx_idx, tx_idx;
  logic          rx_oow, tx_oow;
  logic          rx_we;

  assign rx_req = wbrx_cyc_i & wbrx_stb_i;
  assign tx_req = wbtx_cyc_i & wbtx_stb_i;
  assign rx_idx = wbrx_adr_i[AW+1:2];
  assign tx_idx = wbtx_adr_i[AW+1:2];

`ifdef MINIMAC_WBMEM_ERR_EN
  assign rx_oow = (wbrx_adr_i[31:AW+2] != BASE[31:AW+2]);
  assign tx_oow = (wbtx_adr_i[31:AW+2] != BASE[31:AW+2]);
`else
  assign rx_oow = 1'b0;
  assign tx_oow = 1'b0;
`endif

  // Upper address bits, byte-lane bits and BASE are only consumed by the
  // optional window check.
  logic unused_bits;
  assign unused_bits = ^{wbrx_adr_i, wbtx_adr_i, BASE};

  // RX beat accepted this edge and inside the window.
  assign rx_we = (state_q == StGntRx) & rx_req & ~rx_ack_q & ~rx_err_q & ~rx_oow;

  // RAM storage has no reset; contents survive sys_rst_n.
  always_ff @(posedge sys_clk) begin
    if (rx_we) begin
      mem[rx_idx] <= wbrx_dat_i;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q   <= StIdle;
      last_tx_q <= 1'b1;
      burst_q   <= 1'b0;
      rx_ack_q  <= 1'b0;
      rx_err_q  <= 1'b0;
      tx_ack_q  <= 1'b0;
      tx_err_q  <= 1'b0;
      tx_dat_q  <= 32'h0;
    end else begin
      // Responses last exactly one cycle.
      rx_ack_q <= 1'b0;
      rx_err_q <= 1'b0;
      tx_ack_q <= 1'b0;
      tx_err_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (rx_req && (!tx_req || last_tx_q)) begin
            state_q   <= StGntRx;
            last_tx_q <= 1'b0;
          end else if (tx_req) begin
            state_q   <= StGntTx;
            last_tx_q <= 1'b1;
          end
        end
        StGntRx: begin
          if (!wbrx_cyc_i) begin
            state_q <= StIdle;
          end else if (rx_ack_q || rx_err_q) begin
            // Response cycle ends: keep grant only inside an incrementing burst.
            if (rx_err_q || !burst_q) state_q <= StIdle;
          end else if (wbrx_stb_i) begin
            if (rx_oow) rx_err_q <= 1'b1;
            else        rx_ack_q <= 1'b1;
            burst_q <= (wbrx_cti_i == 3'b010);
          end
        end
        StGntTx: begin
          if (!wbtx_cyc_i) begin
            state_q <= StIdle;
          end else if (tx_ack_q || tx_err_q) begin
            if (tx_err_q || !burst_q) state_q <= StIdle;
          end else if (wbtx_stb_i) begin
            if (tx_oow) begin
              tx_err_q <= 1'b1;
            end else begin
              tx_ack_q <= 1'b1;
              tx_dat_q <= mem[tx_idx];
            end
            burst_q <= (wbtx_cti_i == 3'b010);
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign wbrx_ack_o = rx_ack_q;
  assign wbrx_err_o = rx_err_q;
  assign wbtx_ack_o = tx_ack_q;
  assign wbtx_err_o = tx_err_q;
  assign wbtx_dat_o = tx_dat_q;

endmodule

// File: tb/tb_minimac_wbmem.sv
// Scoreboard bench for minimac_wbmem: masters push expected responses (kind,
// data, cycle of the response) into per-port queues; a monitor pops and
// compares whenever the DUT raises ack or err.
module tb_minimac_wbmem;

  logic        sys_clk, sys_rst_n;
  logic [31:0] wbrx_adr_i, wbrx_dat_i, wbtx_adr_i;
  logic [2:0]  wbrx_cti_i, wbtx_cti_i;
  logic        wbrx_cyc_i, wbrx_stb_i, wbtx_cyc_i, wbtx_stb_i;
  logic        wbrx_ack_o, wbrx_err_o, wbtx_ack_o, wbtx_err_o;
  logic [31:0] wbtx_dat_o;

  minimac_wbmem dut (
    .sys_clk    (sys_clk),
    .sys_rst_n  (sys_rst_n),
    .wbrx_adr_i (wbrx_adr_i),
    .wbrx_cti_i (wbrx_cti_i),
    .wbrx_cyc_i (wbrx_cyc_i),
    .wbrx_stb_i (wbrx_stb_i),
    .wbrx_dat_i (wbrx_dat_i),
    .wbrx_ack_o (wbrx_ack_o),
    .wbrx_err_o (wbrx_err_o),
    .wbtx_adr_i (wbtx_adr_i),
    .wbtx_cti_i (wbtx_cti_i),
    .wbtx_cyc_i (wbtx_cyc_i),
    .wbtx_stb_i (wbtx_stb_i),
    .wbtx_dat_o (wbtx_dat_o),
    .wbtx_ack_o (wbtx_ack_o),
    .wbtx_err_o (wbtx_err_o)
  );

  typedef struct {
    logic        err;
    logic [31:0] dat;
    int          cyc;
  } exp_t;

  exp_t rx_q[$];
  exp_t tx_q[$];
  exp_t rx_e, tx_e;
  int   checks = 0;
  int   failures = 0;
  int   cyc_cnt = 0;

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;
  always @(posedge sys_clk) cyc_cnt <= cyc_cnt + 1;

  // Monitor: every ack/err must match the head of its port's queue.
  always @(negedge sys_clk) begin
    if (sys_rst_n) begin
      if (wbrx_ack_o || wbrx_err_o) begin
        checks++;
        if (rx_q.size() == 0) begin
          failures++;
          $display("FAIL rx_unexpected got ack=%0b err=%0b cycle=%0d required no response",
                   wbrx_ack_o, wbrx_err_o, cyc_cnt);
        end else begin
          rx_e = rx_q.pop_front();
          if (wbrx_err_o !== rx_e.err || wbrx_ack_o !== ~rx_e.err || cyc_cnt != rx_e.cyc) begin
            failures++;
            $display("FAIL rx_beat got ack=%0b err=%0b cycle=%0d required ack=%0b err=%0b cycle=%0d",
                     wbrx_ack_o, wbrx_err_o, cyc_cnt, ~rx_e.err, rx_e.err, rx_e.cyc);
          end
        end
      end
      if (wbtx_ack_o || wbtx_err_o) begin
        checks++;
        if (tx_q.size() == 0) begin
          failures++;
          $display("FAIL tx_unexpected got ack=%0b err=%0b cycle=%0d required no response",
                   wbtx_ack_o, wbtx_err_o, cyc_cnt);
        end else begin
          tx_e = tx_q.pop_front();
          if (wbtx_err_o !== tx_e.err || wbtx_ack_o !== ~tx_e.err || cyc_cnt != tx_e.cyc ||
              (!tx_e.err && wbtx_dat_o !== tx_e.dat)) begin
            failures++;
            $display("FAIL tx_beat got ack=%0b err=%0b dat=%h cycle=%0d required ack=%0b err=%0b dat=%h cycle=%0d",
                     wbtx_ack_o, wbtx_err_o, wbtx_dat_o, cyc_cnt,
                     ~tx_e.err, tx_e.err, tx_e.dat, tx_e.cyc);
          end
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s got=%h required=%h", name, act, req);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge sys_clk);
    #1;
  endtask

  task automatic wait_resp(input bit is_rx, output bit ok);
    ok = 1'b0;
    for (int w = 0; w < 40; w++) begin
      @(negedge sys_clk);
      if (is_rx ? (wbrx_ack_o | wbrx_err_o) : (wbtx_ack_o | wbtx_err_o)) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      failures++;
      $display("FAIL %s_timeout got=no response required=response within 40 cycles",
               is_rx ? "rx" : "tx");
    end
  endtask

  // Beat i: address adr0+4i, data dat0+i, cti 010 except last; response
  // expected lat cycles after start, then every 2 cycles.
  task automatic rx_xfer(input logic [31:0] adr0, input int n, input logic [31:0] dat0,
                         input logic [2:0] last_cti, input int lat, input bit exp_err);
    int   t0;
    bit   ok;
    exp_t e;
    t0 = cyc_cnt;
    for (int i = 0; i < n; i++) begin
      e.err = exp_err;
      e.dat = 32'h0;
      e.cyc = t0 + lat + 2 * i;
      rx_q.push_back(e);
    end
    wbrx_cyc_i = 1'b1;
    for (int i = 0; i < n; i++) begin
      wbrx_stb_i = 1'b1;
      wbrx_adr_i = adr0 + 32'(4 * i);
      wbrx_dat_i = dat0 + 32'(i);
      wbrx_cti_i = (i == n - 1) ? last_cti : 3'b010;
      wait_resp(1'b1, ok);
      @(posedge sys_clk);
      #1;
      if (!ok) break;
    end
    wbrx_cyc_i = 1'b0;
    wbrx_stb_i = 1'b0;
    wbrx_cti_i = 3'b000;
  endtask

  task automatic tx_xfer(input logic [31:0] adr0, input int n, input logic [31:0] exp0,
                         input logic [2:0] last_cti, input int lat, input bit exp_err);
    int   t0;
    bit   ok;
    exp_t e;
    t0 = cyc_cnt;
    for (int i = 0; i < n; i++) begin
      e.err = exp_err;
      e.dat = exp0 + 32'(i);
      e.cyc = t0 + lat + 2 * i;
      tx_q.push_back(e);
    end
    wbtx_cyc_i = 1'b1;
    for (int i = 0; i < n; i++) begin
      wbtx_stb_i = 1'b1;
      wbtx_adr_i = adr0 + 32'(4 * i);
      wbtx_cti_i = (i == n - 1) ? last_cti : 3'b010;
      wait_resp(1'b0, ok);
      @(posedge sys_clk);
      #1;
      if (!ok) break;
    end
    wbtx_cyc_i = 1'b0;
    wbtx_stb_i = 1'b0;
    wbtx_cti_i = 3'b000;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=still running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int   t0;
    bit   ok;
    bit   seen;
    exp_t e;
    sys_rst_n  = 1'b0;
    wbrx_adr_i = '0; wbrx_dat_i = '0; wbrx_cti_i = '0; wbrx_cyc_i = 1'b0; wbrx_stb_i = 1'b0;
    wbtx_adr_i = '0; wbtx_cti_i = '0; wbtx_cyc_i = 1'b0; wbtx_stb_i = 1'b0;
    #23;
    chk("reset_rx_resp", {30'h0, wbrx_ack_o, wbrx_err_o}, 32'h0);
    chk("reset_tx_resp", {30'h0, wbtx_ack_o, wbtx_err_o}, 32'h0);
    chk("reset_tx_dat", wbtx_dat_o, 32'h0);
    sys_rst_n = 1'b1;
    idle(2);

    // Single write then read-back.
    rx_xfer(32'h10, 1, 32'hDEAD_BEEF, 3'b000, 2, 1'b0);
    tx_xfer(32'h10, 1, 32'hDEAD_BEEF, 3'b000, 2, 1'b0);
    idle(3);
    chk("tx_dat_hold", wbtx_dat_o, 32'hDEAD_BEEF);

    // RX 4-beat burst holds the grant; TX waits until it ends.
    fork
      rx_xfer(32'h0, 4, 32'h1, 3'b111, 2, 1'b0);
      tx_xfer(32'h10, 1, 32'hDEAD_BEEF, 3'b000, 11, 1'b0);
    join
    idle(1);
    tx_xfer(32'h0, 4, 32'h1, 3'b111, 2, 1'b0);
    idle(1);

    // Fresh reset: RX wins the first tie, TX wins the next one.
    sys_rst_n = 1'b0;
    idle(1);
    sys_rst_n = 1'b1;
    idle(1);
    fork
      begin
        rx_xfer(32'h20, 1, 32'hA1, 3'b000, 2, 1'b0);
        rx_xfer(32'h24, 1, 32'hA2, 3'b000, 5, 1'b0);
      end
      tx_xfer(32'h10, 1, 32'hDEAD_BEEF, 3'b000, 5, 1'b0);
    join
    idle(1);
    tx_xfer(32'h20, 2, 32'hA1, 3'b111, 2, 1'b0);
    idle(1);

    // Burst aborted by dropping cyc after the second ack.
    rx_xfer(32'h88, 1, 32'h102, 3'b000, 2, 1'b0);
    rx_xfer(32'h80, 2, 32'h100, 3'b010, 2, 1'b0);
    idle(1);
    tx_xfer(32'h80, 3, 32'h100, 3'b111, 2, 1'b0);
    idle(1);

    // Reset pulse in the ack cycle of TX burst beat 2.
    t0 = cyc_cnt;
    e.err = 1'b0; e.dat = 32'h1; e.cyc = t0 + 2; tx_q.push_back(e);
    e.dat = 32'h2; e.cyc = t0 + 4; tx_q.push_back(e);
    wbtx_cyc_i = 1'b1; wbtx_stb_i = 1'b1; wbtx_adr_i = 32'h0; wbtx_cti_i = 3'b010;
    wait_resp(1'b0, ok);
    @(posedge sys_clk);
    #1;
    wbtx_adr_i = 32'h4;
    wait_resp(1'b0, ok);
    #1;
    sys_rst_n = 1'b0;
    #1;
    chk("rst_async_tx_ack", {31'h0, wbtx_ack_o}, 32'h0);
    chk("rst_async_tx_dat", wbtx_dat_o, 32'h0);
    wbtx_cyc_i = 1'b0; wbtx_stb_i = 1'b0; wbtx_cti_i = 3'b000;
    idle(1);
    sys_rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge sys_clk);
      if (wbtx_ack_o || wbrx_ack_o) seen = 1'b1;
    end
    chk("no_ack_after_reset", {31'h0, seen}, 32'h0);
    idle(1);
    tx_xfer(32'h0, 4, 32'h1, 3'b111, 2, 1'b0);
    idle(1);

    // Address just past a 2 KB window.
`ifdef MINIMAC_WBMEM_ERR_EN
    rx_xfer(32'h800, 1, 32'h55, 3'b000, 2, 1'b1);
    tx_xfer(32'h0, 1, 32'h1, 3'b000, 2, 1'b0);
`else
    rx_xfer(32'h800, 1, 32'h55, 3'b000, 2, 1'b0);
    tx_xfer(32'h0, 1, 32'h55, 3'b000, 2, 1'b0);
`endif

    idle(3);
    chk("queues_drained", 32'(rx_q.size() + tx_q.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
